// File: rtl/ph2_sync_sink_pkg.sv
// Shared control definitions for the 2-phase async-to-sync receive sink.
// Holds the default geometry and the capture FSM state encoding.
package ph2_sync_sink_pkg;

  localparam int unsigned DEFAULT_DATA_W      = 32;
  localparam int unsigned DEFAULT_DEPTH       = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // WAIT: idle or capturing; STALL: request seen while the FIFO was full
  typedef enum logic {
    WAIT  = 1'b0,
    STALL = 1'b1
  } sinkState_e;

endpackage

// File: rtl/ph2_sync_sink_sync_ff.sv
// sync_ff: multi-flop synchronizer for a single-bit signal crossing into clk.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears every stage
//   d   - asynchronous input bit
//   q   - synchronized output (last stage)
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous bit through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ph2_sync_sink.sv
// ph2_sync_sink: receives words from a 2-phase bundled-data asynchronous
// pipeline, buffers them in a small FIFO and hands them to a synchronous
// valid/ready consumer.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   inR        - 2-phase request (one toggle per word), synchronized only
//   inData     - bundled data, stable from inR toggle until outA toggle
//   outA       - 2-phase acknowledge back to the sender
//   out_valid  - FIFO head is valid
//   out_data   - FIFO head word
//   out_ready  - consumer accepts the head word
//   count      - FIFO occupancy
module ph2_sync_sink
  import ph2_sync_sink_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inR,
  input  logic [DATA_W-1:0]        inData,
  output logic                     outA,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  sinkState_e        state;
  sinkState_e        stateNext;
  logic              reqS;
  logic              pending;
  logic              push;
  logic              pop;
  logic              full;
  logic              canAccept;
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     countNext;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request crossing: inR is only ever observed through the synchronizer
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_reqSync (
    .clk (clk),
    .rst (rst),
    .d   (inR),
    .q   (reqS)
  );

  // A request is outstanding while the acknowledge phase lags the request
  assign pending = reqS != outA;

  // Extra pointer bit: same index with opposite wrap bit means full
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign pop = out_valid && out_ready;

  // A pop in the same cycle frees the slot the capture will use
  assign canAccept = !full || pop;

  assign countNext = count + PW'(push) - PW'(pop);

  // Capture FSM: next state and capture strobe
  always_comb begin
    stateNext = state;
    push      = 1'b0;
    case (state)
      WAIT: begin
        if (pending) begin
          if (canAccept) begin
            push = 1'b1;
          end else begin
            stateNext = STALL;
          end
        end
      end
      STALL: begin
        if (!pending) begin
          stateNext = WAIT;
        end else if (canAccept) begin
          push      = 1'b1;
          stateNext = WAIT;
        end
      end
      default: stateNext = WAIT;
    endcase
  end

  // Control state: FSM, acknowledge phase, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT;
      outA      <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      out_valid <= countNext != '0;
      if (push) begin
        outA  <= ~outA;
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
    end
  end

  // Storage has no reset; contents are only visible through valid entries
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr[AW-1:0]] <= inData;
    end
  end

  assign out_data = mem[rdPtr[AW-1:0]];

endmodule

// File: tb/tb_ph2_sync_sink.sv
// Self-checking bench for ph2_sync_sink: a 2-phase sender model, a
// valid/ready consumer and a queue of sent words as the reference.
module tb_ph2_sync_sink;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              inR;
  logic [DATA_W-1:0] inData;
  logic              outA;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  // Words handed to the DUT and not yet delivered, in order
  logic [DATA_W-1:0] sentQ [$];

  ph2_sync_sink #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inR       (inR),
    .inData    (inData),
    .outA      (outA),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // 2-phase sender: toggle, wait for the matching acknowledge
  task automatic sendWord(input logic [DATA_W-1:0] d, input bit scramble);
    int w;
    inData = d;
    inR    = ~inR;
    sentQ.push_back(d);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (outA !== inR && w < 60);
    total++;
    if (outA !== inR) begin
      bad++;
      $display("FAIL handshake_timeout outA=%0b expected=%0b", outA, inR);
    end
    if (scramble) inData = $urandom;
  endtask

  task automatic sendStream(input int n, input int base, input bit rnd, input int maxIdle);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
      sendWord(d, 1'b1);
      if (maxIdle > 0) repeat ($urandom_range(0, maxIdle)) @(negedge clk);
    end
  endtask

  // Consumer: mode 0 toggles ready every cycle, mode 1 randomizes it
  task automatic consume(input int nWords, input int mode);
    int got = 0;
    int cyc = 0;
    logic prevHold = 1'b0;
    logic [DATA_W-1:0] prevData = '0;
    logic newReady;
    logic [DATA_W-1:0] exp;
    while (got < nWords && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      total++;
      if (out_valid !== (count != 0)) begin
        bad++;
        $display("FAIL valid_vs_count out_valid=%0b count=%0d", out_valid, count);
      end
      total++;
      if (count > DEPTH) begin
        bad++;
        $display("FAIL count_bound count=%0d max=%0d", count, DEPTH);
      end
      if (prevHold) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prevData) begin
          bad++;
          $display("FAIL hold_stable valid=%0b data=%h expected valid=1 data=%h",
                   out_valid, out_data, prevData);
        end
      end
      newReady  = (mode == 0) ? ~out_ready : 1'($urandom_range(0, 1));
      out_ready = newReady;
      if (out_valid && newReady) begin
        total++;
        if (sentQ.size() == 0) begin
          bad++;
          $display("FAIL extra_word data=%h expected=none", out_data);
        end else begin
          exp = sentQ.pop_front();
          if (out_data !== exp) begin
            bad++;
            $display("FAIL order data=%h expected=%h", out_data, exp);
          end
        end
        got++;
      end
      prevHold = out_valid && !newReady;
      prevData = out_data;
    end
    total++;
    if (got != nWords) begin
      bad++;
      $display("FAIL consume_timeout got=%0d expected=%0d", got, nWords);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic checkEmpty(input string tag);
    total++;
    if (count !== 0 || out_valid !== 1'b0 || sentQ.size() != 0) begin
      bad++;
      $display("FAIL %s_empty count=%0d valid=%0b left=%0d expected 0/0/0",
               tag, count, out_valid, sentQ.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inR = 1'b0; inData = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (outA !== 1'b0 || out_valid !== 1'b0 || count !== 0) begin
      bad++;
      $display("FAIL reset_state outA=%0b valid=%0b count=%0d expected 0/0/0",
               outA, out_valid, count);
    end
    total++;
    if (dut.state !== ph2_sync_sink_pkg::WAIT) begin
      bad++;
      $display("FAIL reset_fsm state=%0d expected=%0d", dut.state, ph2_sync_sink_pkg::WAIT);
    end
    rst = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] w;
    w = 32'hA5A5_0001;
    inData = w; inR = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outA !== 1'b0) begin
      bad++; $display("FAIL lat_edge1 outA=%0b expected=0", outA);
    end
    @(negedge clk);
    total++;
    if (outA !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL lat_edge2 outA=%0b valid=%0b expected 0/0", outA, out_valid);
    end
    @(negedge clk);
    total++;
    if (outA !== 1'b1 || out_valid !== 1'b1 || out_data !== w) begin
      bad++;
      $display("FAIL lat_capture outA=%0b valid=%0b data=%h expected 1/1/%h",
               outA, out_valid, out_data, w);
    end
    inData = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || count !== 0 || outA !== 1'b1) begin
      bad++;
      $display("FAIL lat_pulse valid=%0b count=%0d outA=%0b expected 0/0/1",
               out_valid, count, outA);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic phase4;
    logic [DATA_W-1:0] exp;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) sendWord(DATA_W'(i), 1'b0);
    total++;
    if (count !== 4) begin
      bad++; $display("FAIL stall_fill count=%0d expected=4", count);
    end
    phase4 = inR;
    inData = DATA_W'(5); inR = ~inR; sentQ.push_back(DATA_W'(5));
    repeat (6) @(negedge clk);
    total++;
    if (count !== 4 || outA !== phase4 || dut.state !== ph2_sync_sink_pkg::STALL) begin
      bad++;
      $display("FAIL stall_hold count=%0d outA=%0b state=%0d expected 4/%0b/%0d",
               count, outA, dut.state, phase4, ph2_sync_sink_pkg::STALL);
    end
    out_ready = 1'b1;
    exp = sentQ.pop_front();
    total++;
    if (out_data !== exp) begin
      bad++; $display("FAIL stall_head data=%h expected=%h", out_data, exp);
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (count !== 4 || outA !== inR || out_data !== DATA_W'(2)
        || dut.state !== ph2_sync_sink_pkg::WAIT) begin
      bad++;
      $display("FAIL stall_release count=%0d outA=%0b data=%h state=%0d expected 4/%0b/2/%0d",
               count, outA, out_data, dut.state, inR, ph2_sync_sink_pkg::WAIT);
    end
    consume(4, 1);
    checkEmpty("stall");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    fork
      sendStream(16, 'h10, 1'b0, 0);
      consume(16, 0);
    join
    checkEmpty("b2b");
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) sendWord(DATA_W'($urandom), 1'b1);
    total++;
    if (count !== DEPTH) begin
      bad++; $display("FAIL fpp_fill count=%0d expected=%0d", count, DEPTH);
    end
    inData = DATA_W'($urandom); inR = ~inR; sentQ.push_back(inData);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    exp = sentQ.pop_front();
    total++;
    if (out_data !== exp) begin
      bad++; $display("FAIL fpp_head data=%h expected=%h", out_data, exp);
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (count !== DEPTH || outA !== inR || dut.state !== ph2_sync_sink_pkg::WAIT) begin
      bad++;
      $display("FAIL fpp_same_cycle count=%0d outA=%0b state=%0d expected %0d/%0b/%0d",
               count, outA, dut.state, DEPTH, inR, ph2_sync_sink_pkg::WAIT);
    end
    consume(DEPTH, 1);
    checkEmpty("fpp");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) sendWord(DATA_W'($urandom), 1'b1);
    total++;
    if (count !== 3) begin
      bad++; $display("FAIL rstmid_fill count=%0d expected=3", count);
    end
    inData = DATA_W'($urandom); inR = ~inR;
    @(negedge clk);
    rst = 1'b1; inR = 1'b0;
    @(negedge clk);
    total++;
    if (count !== 0 || out_valid !== 1'b0 || outA !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_clear count=%0d valid=%0b outA=%0b expected 0/0/0",
               count, out_valid, outA);
    end
    rst = 1'b0;
    sentQ.delete();
    repeat (SYNC + 2) @(negedge clk);
    total++;
    if (count !== 0 || outA !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet count=%0d outA=%0b expected 0/0", count, outA);
    end
    fork
      sendWord(32'h0BAD_F00D, 1'b1);
      consume(1, 1);
    join
    checkEmpty("rstmid");
  endtask

  task automatic test_random();
    out_ready = 1'b0;
    fork
      sendStream(40, 0, 1'b1, 3);
      consume(40, 1);
    join
    checkEmpty("random");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ph2_sync_sink.md
PH2_SYNC_SINK -- requirements
Module: ph2_sync_sink

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of the bundled data word.
REQ-002 The block SHALL have parameter DEPTH, default 4: receive FIFO entries, a power of two, minimum 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: flops in the request synchronizer, minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port inR, input, 1 bit: 2-phase request from the asynchronous delay-matched pipeline; each toggle means one word.
REQ-007 The block SHALL have port inData, input, DATA_W bits: bundled data; the sender holds it stable from the inR toggle until the matching outA toggle.
REQ-008 The block SHALL have port outA, output, 1 bit: 2-phase acknowledge to the asynchronous sender.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the FIFO head word is valid.
REQ-010 The block SHALL have port out_data, output, DATA_W bits: the FIFO head word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the synchronous consumer accepts the head word.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-013 The block SHALL pass inR through SYNC_STAGES flops to produce req_s; the block SHALL NOT use inR for anything else.
REQ-014 The block SHALL define pending as req_s != outA.
REQ-015 The block SHALL have state WAIT: when pending and count<DEPTH, it SHALL write inData into the FIFO and toggle outA at the same clock edge.
REQ-016 In WAIT, when pending and count==DEPTH, the block SHALL go to STALL with no write and outA unchanged.
REQ-017 In STALL, the block SHALL capture, toggle outA and return to WAIT in the first cycle count<DEPTH, including the cycle a pop frees the last slot.
REQ-018 The block SHALL capture at most one word per inR toggle; outA SHALL toggle exactly once per capture.
REQ-019 Latency: with an empty FIFO, an inR toggle sampled at edge N SHALL produce the capture and outA toggle at edge N+SYNC_STAGES; out_valid SHALL rise at that same edge.
REQ-020 The block SHALL pop when out_valid && out_ready; out_data SHALL then present the next entry on the following cycle.
REQ-021 out_valid and out_data SHALL be stable while out_valid && !out_ready.
REQ-022 On a push and pop in the same cycle, count SHALL be unchanged and both SHALL take effect, including at count==DEPTH.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH and SHALL carry one extra bit so full and empty are distinguished.
REQ-024 A pop when count==0 SHALL be ignored.
REQ-025 out_valid SHALL equal (count!=0).

Reset
REQ-026 While rst is high at a clock edge, the block SHALL clear the synchronizer flops, outA, the pointers and count, set out_valid=0 and state=WAIT; out_data is don't-care.
REQ-027 On reset mid-operation, the block SHALL discard pending requests and stored words; the asynchronous sender SHALL share rst so that its inR also returns to 0.
REQ-028 The first request after reset SHALL be detected only once rst has been low for SYNC_STAGES edges.

Structure
REQ-029 The state encoding (WAIT, STALL) and the default DATA_W, DEPTH and SYNC_STAGES SHALL reside in the shared control package.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_ff (parameter STAGES, 1-bit input and output, clk/rst), reusable by other sync/async crossings.
REQ-031 The FIFO storage SHALL be inline register arrays; no vendor primitives SHALL be used.

Verification
REQ-032 The bench SHALL cover: reset, toggle inR 0->1 with inData=0xA5A5_0001, out_ready=1 -> outA becomes 1 exactly 2 edges after sampling, out_valid pulses 1 cycle with out_data=0xA5A5_0001.
REQ-033 The bench SHALL cover: out_ready=0, five handshaken words 1..5 -> words 1-4 captured, count=4, state STALL, outA still at phase of word 4; then one pop -> word 5 captured the same cycle the slot frees, count stays 4.
REQ-034 The bench SHALL cover: continuous handshake of 16 words 0x10..0x1F with out_ready toggling every cycle -> all 16 delivered in order, pointer wrap exercised, no duplicates.
REQ-035 The bench SHALL cover: assert rst while count=3 and a request is pending -> next cycle count=0, out_valid=0, outA=0; a new request after release is received normally.
REQ-036 The bench SHALL cover: inData changed after the outA toggle -> the captured value equals the pre-toggle value.
REQ-037 The bench SHALL cover: a simultaneous push and pop at count=DEPTH -> count stays DEPTH and order is preserved.
